// File: rtl/adder_accum_stage_pkg.sv
// rtl/adder_accum_stage_pkg.sv - shared widths, state encoding and saturating increment
package adder_accum_stage_pkg;

  localparam int ADD_WIDTH = 22;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Increment v by one, sticking at the all-ones value of a w-bit counter (w < 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/adder_accum_stage_if.sv
// rtl/adder_accum_stage_if.sv - operand stream, result stream and external adder pins
interface adder_accum_stage_if
  import adder_accum_stage_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int CNT_W = CNT_W_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_ovf;
  logic [CNT_W-1:0] out_cnt;

  // The accumulator stage itself.
  modport slave (
    input  in_valid, in_data, in_last, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_ovf, out_cnt
  );

  // The surroundings: upstream source, adder and downstream sink.
  modport master (
    output in_valid, in_data, in_last, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_ovf, out_cnt
  );

endinterface

// File: rtl/adder_accum_stage_sat_counter.sv
// rtl/adder_accum_stage_sat_counter.sv - saturating counter with synchronous clear
module adder_accum_stage_sat_counter
  import adder_accum_stage_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count_nxt
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Value including this cycle's increment; the parent captures it at frame end.
  always_comb begin
    count_nxt = count_q;
    if (inc) begin
      count_nxt = CNT_W'(sat_inc(32'(count_q), CNT_W));
    end
  end

  // Clear wins over increment so a closing beat restarts the next frame at zero.
  always_comb begin
    count_d = count_nxt;
    if (clr) begin
      count_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/adder_accum_stage.sv
// rtl/adder_accum_stage.sv - frame accumulator around an external ripple-carry adder
module adder_accum_stage
  import adder_accum_stage_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  adder_accum_stage_if.slave s
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_ovf_q, out_ovf_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] ovf_nxt;
  logic             accept;
  logic             frame_end;

  // Handshake, adder pins and result port; in_ready is held low while in reset.
  always_comb begin
    s.in_ready  = rst_n && (state_q == ACCUM);
    accept      = s.in_valid && s.in_ready && !clr;
    frame_end   = accept && s.in_last;
    s.add_a     = acc_q;
    s.add_b     = s.in_data;
    s.add_cin   = 1'b0;
    s.out_valid = (state_q == HOLD);
    s.out_sum   = out_sum_q;
    s.out_ovf   = out_ovf_q;
    s.out_cnt   = out_cnt_q;
  end

  adder_accum_stage_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr || frame_end),
    .inc       (accept),
    .count_nxt (cnt_nxt)
  );

  adder_accum_stage_sat_counter #(.CNT_W(CNT_W)) u_ovf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr || frame_end),
    .inc       (accept && s.add_cout),
    .count_nxt (ovf_nxt)
  );

  // Next state: accumulate beats, latch the result on the last one, release on handshake.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;
    out_cnt_d = out_cnt_q;
    if (clr) begin
      state_d = ACCUM;
      acc_d   = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (frame_end) begin
            out_sum_d = s.add_sum;
            out_ovf_d = ovf_nxt;
            out_cnt_d = cnt_nxt;
            acc_d     = '0;
            state_d   = HOLD;
          end else if (accept) begin
            acc_d = s.add_sum;
          end
        end
        HOLD: begin
          if (s.out_ready) begin
            state_d = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // State, accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      out_sum_q <= '0;
      out_ovf_q <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_adder_accum_stage.sv
// tb/tb_adder_accum_stage.sv - vector, directed and randomized checks of the accumulator stage
module tb_adder_accum_stage;

  typedef logic [21:0] beat_q_t[$];

  typedef struct {
    int          n;
    logic [21:0] beats [6];
    logic [21:0] exp_sum;
    int          exp_ovf;
    int          exp_cnt;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [21:0] in_data;
  logic        in_last;
  logic        out_ready;

  int checks;
  int failures;

  vec_t vecs [5];

  adder_accum_stage_if #(.WIDTH(22), .CNT_W(8)) m1 ();
  adder_accum_stage_if #(.WIDTH(22), .CNT_W(2)) m2 ();

  assign m1.in_valid  = in_valid;
  assign m1.in_data   = in_data;
  assign m1.in_last   = in_last;
  assign m1.out_ready = out_ready;
  assign {m1.add_cout, m1.add_sum} = {1'b0, m1.add_a} + {1'b0, m1.add_b} + {22'd0, m1.add_cin};

  assign m2.in_valid  = in_valid;
  assign m2.in_data   = in_data;
  assign m2.in_last   = in_last;
  assign m2.out_ready = out_ready;
  assign {m2.add_cout, m2.add_sum} = {1'b0, m2.add_a} + {1'b0, m2.add_b} + {22'd0, m2.add_cin};

  adder_accum_stage #(.WIDTH(22), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .s     (m1)
  );

  adder_accum_stage #(.WIDTH(22), .CNT_W(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .s     (m2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the stage takes it.
  task automatic drive_beat(input logic [21:0] d, input logic last);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    t = 0;
    while (!m1.in_ready && t < 20) begin
      step();
      t++;
    end
    if (!m1.in_ready) chk("in_ready_timeout", 0, 1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  // Called right after a last-beat accept with out_ready=1: result drains next edge.
  task automatic finish_handshake(input string tag);
    step();
    chk({tag, "_valid_drop"}, m1.out_valid, 0);
    chk({tag, "_ready_back"}, m1.in_ready, 1);
  endtask

  // Frame result from plain integer arithmetic: wrap the sum, count wraps, clamp counts.
  function automatic void model(input beat_q_t q, input int cw,
                                output logic [21:0] s, output int ovf, output int cnt);
    longint run;
    int     wraps;
    int     cap;
    run   = 0;
    wraps = 0;
    cap   = (1 << cw) - 1;
    foreach (q[i]) begin
      run = run + longint'(q[i]);
      if (run >= 64'h400000) begin
        wraps++;
        run = run - 64'h400000;
      end
    end
    s   = run[21:0];
    ovf = (wraps > cap) ? cap : wraps;
    cnt = (q.size() > cap) ? cap : q.size();
  endfunction

  initial begin
    beat_q_t     q;
    logic [21:0] e_sum;
    int          e_ovf;
    int          e_cnt;
    logic [21:0] e2_sum;
    int          e2_ovf;
    int          e2_cnt;
    int          n;

    checks   = 0;
    failures = 0;

    vecs[0] = '{3, '{22'h000005, 22'h000007, 22'h000009, 22'h0, 22'h0, 22'h0}, 22'h000015, 0, 3};
    vecs[1] = '{3, '{22'h3FFFFF, 22'h000001, 22'h000002, 22'h0, 22'h0, 22'h0}, 22'h000002, 1, 3};
    vecs[2] = '{1, '{22'h123456, 22'h0, 22'h0, 22'h0, 22'h0, 22'h0}, 22'h123456, 0, 1};
    vecs[3] = '{3, '{22'h3FFFFF, 22'h3FFFFF, 22'h3FFFFF, 22'h0, 22'h0, 22'h0}, 22'h3FFFFD, 2, 3};
    vecs[4] = '{4, '{22'h200000, 22'h200000, 22'h200000, 22'h200000, 22'h0, 22'h0}, 22'h000000, 2, 4};

    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    #3;
    chk("rst_out_valid", m1.out_valid, 0);
    chk("rst_out_sum", m1.out_sum, 0);
    chk("rst_out_cnt", m1.out_cnt, 0);
    chk("rst_out_ovf", m1.out_ovf, 0);
    chk("rst_in_ready", m1.in_ready, 0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", m1.in_ready, 1);
    chk("post_rst_add_a", m1.add_a, 0);
    chk("add_cin_zero", m1.add_cin, 0);
    in_data = 22'h2AAAAA;
    #1;
    chk("add_b_follows", m1.add_b, 22'h2AAAAA);
    in_data = '0;

    // Table vectors.
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        drive_beat(vecs[i].beats[j], j == vecs[i].n - 1);
      end
      chk($sformatf("vec%0d_valid", i), m1.out_valid, 1);
      chk($sformatf("vec%0d_sum", i), m1.out_sum, vecs[i].exp_sum);
      chk($sformatf("vec%0d_ovf", i), m1.out_ovf, vecs[i].exp_ovf);
      chk($sformatf("vec%0d_cnt", i), m1.out_cnt, vecs[i].exp_cnt);
      finish_handshake($sformatf("vec%0d", i));
    end

    // Backpressure: result held for 4 cycles, a waiting beat is not taken.
    out_ready = 1'b0;
    drive_beat(22'h000001, 1'b0);
    drive_beat(22'h000002, 1'b1);
    chk("bp_valid_rise", m1.out_valid, 1);
    in_valid = 1'b1;
    in_data  = 22'h000010;
    in_last  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("bp%0d_in_ready", k), m1.in_ready, 0);
      chk($sformatf("bp%0d_valid", k), m1.out_valid, 1);
      chk($sformatf("bp%0d_sum", k), m1.out_sum, 22'h000003);
      chk($sformatf("bp%0d_cnt", k), m1.out_cnt, 2);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", m1.out_valid, 0);
    chk("bp_release_in_ready", m1.in_ready, 1);
    step();
    chk("bp_held_beat_valid", m1.out_valid, 1);
    chk("bp_held_beat_sum", m1.out_sum, 22'h000010);
    chk("bp_held_beat_cnt", m1.out_cnt, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    finish_handshake("bp_end");

    // clr mid-frame, with a concurrent beat that must be dropped.
    drive_beat(22'd10, 1'b0);
    drive_beat(22'd20, 1'b0);
    in_valid = 1'b1;
    in_data  = 22'd30;
    clr      = 1'b1;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_acc_zero", m1.add_a, 0);
    chk("clr_no_valid", m1.out_valid, 0);
    drive_beat(22'd40, 1'b1);
    chk("clr_frame_sum", m1.out_sum, 22'h000028);
    chk("clr_frame_cnt", m1.out_cnt, 1);
    chk("clr_frame_ovf", m1.out_ovf, 0);
    finish_handshake("clr_frame");

    // clr while holding a result: valid drops, values are kept.
    out_ready = 1'b0;
    drive_beat(22'h000077, 1'b1);
    chk("clr_hold_valid_before", m1.out_valid, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_hold_valid", m1.out_valid, 0);
    chk("clr_hold_in_ready", m1.in_ready, 1);
    chk("clr_hold_sum_kept", m1.out_sum, 22'h000077);
    out_ready = 1'b1;

    // Six max beats: the 2-bit counters saturate, the 8-bit ones do not.
    for (int i = 0; i < 6; i++) begin
      drive_beat(22'h3FFFFF, i == 5);
    end
    chk("sat2_cnt", m2.out_cnt, 3);
    chk("sat2_ovf", m2.out_ovf, 3);
    chk("sat2_sum", m2.out_sum, 22'h3FFFFA);
    chk("sat8_cnt", m1.out_cnt, 6);
    chk("sat8_ovf", m1.out_ovf, 5);
    finish_handshake("sat");

    // Randomized frames against the arithmetic model.
    for (int f = 0; f < 30; f++) begin
      q.delete();
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 2) == 0) q.push_back(22'h3FFFFF - 22'($urandom_range(0, 15)));
        else q.push_back(22'($urandom));
      end
      for (int j = 0; j < n; j++) begin
        repeat ($urandom_range(0, 2)) step();
        drive_beat(q[j], j == n - 1);
      end
      model(q, 8, e_sum, e_ovf, e_cnt);
      model(q, 2, e2_sum, e2_ovf, e2_cnt);
      chk($sformatf("rnd%0d_sum", f), m1.out_sum, e_sum);
      chk($sformatf("rnd%0d_ovf", f), m1.out_ovf, e_ovf);
      chk($sformatf("rnd%0d_cnt", f), m1.out_cnt, e_cnt);
      chk($sformatf("rnd%0d_sum2", f), m2.out_sum, e2_sum);
      chk($sformatf("rnd%0d_ovf2", f), m2.out_ovf, e2_ovf);
      chk($sformatf("rnd%0d_cnt2", f), m2.out_cnt, e2_cnt);
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        chk($sformatf("rnd%0d_stall_valid", f), m1.out_valid, 1);
        chk($sformatf("rnd%0d_stall_sum", f), m1.out_sum, e_sum);
        out_ready = 1'b1;
      end
      finish_handshake($sformatf("rnd%0d", f));
    end

    // Asynchronous reset in the middle of a frame.
    drive_beat(22'h000055, 1'b1);
    finish_handshake("pre_rst");
    drive_beat(22'h000055, 1'b0);
    drive_beat(22'h000066, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_sum", m1.out_sum, 0);
    chk("arst_out_cnt", m1.out_cnt, 0);
    chk("arst_out_ovf", m1.out_ovf, 0);
    chk("arst_out_valid", m1.out_valid, 0);
    chk("arst_in_ready", m1.in_ready, 0);
    chk("arst_add_a", m1.add_a, 0);
    step();
    rst_n = 1'b1;
    step();
    drive_beat(22'h000001, 1'b1);
    chk("arst_frame_sum", m1.out_sum, 22'h000001);
    chk("arst_frame_cnt", m1.out_cnt, 1);
    chk("arst_frame_ovf", m1.out_ovf, 0);
    finish_handshake("arst_frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_accum_stage.md
Name: adder_accum_stage

Overview:
- Streaming accumulator stage wrapped around the team's 22-bit ripple-carry adder.
- Drives the adder's operand and carry-in pins, and registers the adder's sum and carry-out back into a running total.
- Accepts a valid/ready operand stream framed by a last flag, and emits one accumulated result per frame on a valid/ready output port.
- Also emits a carry-out (overflow) count and an operand count for each frame.

Parameters:
- WIDTH, 22: operand and sum width; must match the adder instance width.
- CNT_W, 8: width of the operand counter and the overflow counter. Both saturate.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset; asserts immediately, releases synchronously to clk.
- clr  in  1  synchronous clear of the frame in progress.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  stage can accept an operand beat.
- in_data  in  WIDTH  operand.
- in_last  in  1  marks the final operand of a frame.
- add_a  out  WIDTH  to adder operand a; equals the accumulator register.
- add_b  out  WIDTH  to adder operand b; equals in_data (combinational).
- add_cin  out  1  to adder cin; constant 0.
- add_sum  in  WIDTH  from adder sum.
- add_cout  in  1  from adder cout.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH  accumulated frame sum, modulo 2^WIDTH.
- out_ovf  out  CNT_W  number of beats in the frame whose add_cout was 1; saturates.
- out_cnt  out  CNT_W  number of beats in the frame; saturates.

Behaviour:
- States:
  - ACCUM: in_ready=1.
  - HOLD: in_ready=0, out_valid=1.
- Reset values:
  - State is ACCUM.
  - The accumulator (acc), ovf_r, cnt_r, out_sum, out_ovf, out_cnt and out_valid are all 0.
  - in_ready is 1 as soon as rst_n is high.
- The adder path is purely combinational inside the cycle: add_a=acc, add_b=in_data, add_cin=0. No adder pipeline is assumed.
- Accept condition: in_valid && in_ready && !clr. On an accepted non-last beat:
  - acc <= add_sum.
  - ovf_r <= sat(ovf_r + add_cout).
  - cnt_r <= sat(cnt_r + 1).
- On an accepted beat with in_last=1:
  - out_sum <= add_sum.
  - out_ovf <= sat(ovf_r + add_cout).
  - out_cnt <= sat(cnt_r + 1).
  - acc, ovf_r and cnt_r are set to 0.
  - out_valid <= 1 and the state moves to HOLD.
- Latency: out_valid rises in the cycle after the last beat is accepted. Throughput is one operand beat per cycle while in ACCUM.
- In HOLD, out_* hold stable until out_valid && out_ready. On that cycle out_valid <= 0 and the state returns to ACCUM. in_ready goes to 1 the following cycle; there is no same-cycle pass-through.
- Saturation: a counter already at 2^CNT_W-1 stays there and never wraps.
- A single-beat frame (in_last on the first beat) gives out_sum = in_data, out_cnt=1, out_ovf=0.
- clr=1, in any state:
  - acc, ovf_r and cnt_r are set to 0, and out_valid <= 0.
  - The state moves to ACCUM and any concurrent input beat is dropped (clr has priority).
  - out_sum, out_ovf and out_cnt keep their values but are invalid.
- in_valid while in HOLD: the beat is not accepted and the upstream must hold it.
- rst_n deasserted mid-frame: all partial state is lost immediately and the frame is discarded.
- add_cout is sampled only on accepted beats.

Decomposition:
- Shared package holds:
  - ADD_WIDTH = 22, CNT_W_DEF = 8.
  - The state enum {ACCUM, HOLD}.
  - A saturating-increment function.
- The adder is instantiated by the parent, not inside this block, so it can be swapped for another adder topology.
- One natural sub-module: sat_counter (CNT_W, synchronous clear, increment-enable). It is instantiated twice, for the operand count and the overflow count.

Test Plan:
- Frame 5, 7, 9 (last on 9), out_ready=1 -> out_valid one cycle after the last accept; out_sum=0x000015, out_cnt=3, out_ovf=0.
- Frame 0x3FFFFF, 0x000001, 0x000002 (last) -> out_sum=0x000002, out_ovf=1, out_cnt=3.
- out_ready=0 for 4 cycles after a frame completes:
  - in_ready stays 0 and out_* stay stable.
  - A new beat held on in_valid is not accepted.
  - Once out_ready=1, in_ready=1 on the next cycle and the held beat is accepted.
- clr pulsed in the middle of frame 10, 20 (then clr with beat 30), then 40 (last) -> out_sum=0x000028, out_cnt=1. The beat 30 is dropped.
- CNT_W=2, six beats of 0x3FFFFF with the last on the sixth -> out_cnt=3 and out_ovf=3 (both saturated); out_sum=0x3FFFFA.
- rst_n pulled low asynchronously mid-frame, then frame 1 (last) -> all outputs 0 during reset; after release, out_sum=0x000001, out_cnt=1.
